// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry circular store FIFO draining to data memory, with per-byte
// youngest-entry load forwarding. Optional store coalescing is compiled in by SB_COALESCE_EN.
// Latency: an accepted store becomes visible to forwarding and drain on the next cycle.
// The drain write and all forwarding results are combinational from the current contents.
// Backpressure: st_ready is derived from registered occupancy, so a same-cycle pop never raises it.
// A merge-capable store is still accepted when full. The drain waits while mem_grant is low.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     st_valid,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic [3:0]               st_byte_en,
   output logic                     st_ready,
   input  logic [31:0]              ld_addr,
   input  logic [3:0]               ld_byte_en,
   output logic                     ld_hit,
   output logic                     ld_conflict,
   output logic [31:0]              ld_data,
   input  logic                     mem_grant,
   output logic                     mem_we,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_byte_en,
   output logic                     sb_empty,
   output logic [$clog2(DEPTH):0]   sb_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   // Entry storage; only slots between head and tail carry meaning.
   logic [31:0]   ent_addr [DEPTH];
   logic [31:0]   ent_data [DEPTH];
   logic [3:0]    ent_be   [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          pop;
   logic          alloc;

   // Forwarding intermediates.
   logic [3:0]    fwd_be;
   logic [31:0]   fwd_data;
   logic [3:0]    covered;

   // Only the word index bits of a load address take part in matching.
   logic          ld_addr_unused;
   assign ld_addr_unused = ^{ld_addr[31:14], ld_addr[1:0]};

   assign sb_empty = (sb_count == '0);

   // Drain port: head entry goes out whenever the memory grants the write port.
   assign pop         = !sb_empty && mem_grant;
   assign mem_we      = pop;
   assign mem_addr    = sb_empty ? 32'h0 : ent_addr[head];
   assign mem_wdata   = sb_empty ? 32'h0 : ent_data[head];
   assign mem_byte_en = sb_empty ? 4'h0  : ent_be[head];

`ifdef SB_COALESCE_EN
   logic [PW-1:0] youngest;
   logic          merge_ok;
   logic          merge;

   // A store may fold into the youngest entry when it targets the same word,
   // unless that entry is the head being written to memory this very cycle.
   assign youngest = tail - PTR_ONE;
   assign merge_ok = !sb_empty
                     && (ent_addr[youngest][13:2] == st_addr[13:2])
                     && !(pop && (sb_count == CNT_ONE));
   assign st_ready = (sb_count < CNT_FULL) || merge_ok;
   assign merge    = st_valid && merge_ok;
   assign alloc    = st_valid && st_ready && !merge_ok;
`else
   assign st_ready = (sb_count < CNT_FULL);
   assign alloc    = st_valid && st_ready;
`endif

   // Pointer and occupancy bookkeeping; reset discards everything pending.
   always_ff @(posedge clk) begin
      if (!reset) begin
         head     <= '0;
         tail     <= '0;
         sb_count <= '0;
      end else begin
         if (pop) begin
            head <= head + PTR_ONE;
         end
         if (alloc) begin
            tail <= tail + PTR_ONE;
         end
         case ({alloc, pop})
            2'b10:   sb_count <= sb_count + CNT_ONE;
            2'b01:   sb_count <= sb_count - CNT_ONE;
            default: sb_count <= sb_count;
         endcase
      end
   end

   // Entry payload writes: new allocation at tail, or lane merge into the youngest entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (alloc) begin
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
            ent_be[tail]   <= st_byte_en;
         end
`ifdef SB_COALESCE_EN
         if (merge) begin
            for (int b = 0; b < 4; b++) begin
               if (st_byte_en[b]) begin
                  ent_data[youngest][8*b +: 8] <= st_data[8*b +: 8];
               end
            end
            ent_be[youngest] <= ent_be[youngest] | st_byte_en;
         end
`endif
      end
   end

   // Per-lane forwarding: walk entries oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_be   = 4'h0;
      fwd_data = 32'h0;
      for (int a = 0; a < DEPTH; a++) begin
         if ((CW'(a) < sb_count)
             && (ent_addr[head + PW'(a)][13:2] == ld_addr[13:2])) begin
            for (int b = 0; b < 4; b++) begin
               if (ent_be[head + PW'(a)][b]) begin
                  fwd_be[b]          = 1'b1;
                  fwd_data[8*b +: 8] = ent_data[head + PW'(a)][8*b +: 8];
               end
            end
         end
      end
   end

   // Load result classification; only requested lanes are returned.
   always_comb begin
      covered     = fwd_be & ld_byte_en;
      ld_hit      = (ld_byte_en != 4'h0) && (covered == ld_byte_en);
      ld_conflict = (covered != 4'h0) && (covered != ld_byte_en);
      ld_data     = 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (covered[b]) begin
            ld_data[8*b +: 8] = fwd_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random traffic.
// Every cycle all outputs are compared against a queue-based reference model.
// The model follows the buffer's rules directly (oldest at front, youngest at back).
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_byte_en;
   logic        st_ready;
   logic [31:0] ld_addr;
   logic [3:0]  ld_byte_en;
   logic        ld_hit;
   logic        ld_conflict;
   logic [31:0] ld_data;
   logic        mem_grant;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_en;
   logic        sb_empty;
   logic [$clog2(DEPTH):0] sb_count;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte_en(st_byte_en),
      .st_ready(st_ready),
      .ld_addr(ld_addr), .ld_byte_en(ld_byte_en),
      .ld_hit(ld_hit), .ld_conflict(ld_conflict), .ld_data(ld_data),
      .mem_grant(mem_grant), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
      .sb_empty(sb_empty), .sb_count(sb_count)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ent_t;

   ent_t        q[$];
   logic [31:0] accepted[$];
   logic [31:0] drained[$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic g,
                        input logic [31:0] la, input logic [3:0] lbe);
      st_valid = v; st_addr = a; st_data = d; st_byte_en = be;
      mem_grant = g; ld_addr = la; ld_byte_en = lbe;
   endtask

   // Reference forwarding: for each requested lane, youngest matching entry with that lane.
   function automatic void model_fwd(output logic [3:0] cov, output logic [31:0] fd);
      cov = 4'h0;
      fd  = 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (ld_byte_en[b]) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
               if (q[i].addr[13:2] == ld_addr[13:2] && q[i].be[b]) begin
                  cov[b] = 1'b1;
                  fd[8*b +: 8] = q[i].data[8*b +: 8];
                  break;
               end
            end
         end
      end
   endfunction

   // Compare every output against the model, then advance one clock and update the model.
   task automatic tick();
      logic [3:0]  cov;
      logic [31:0] fd;
      logic        exp_ready;
      logic        exp_we;
      logic        merge;
      int          n;
      #1;
      n = q.size();
      merge = 1'b0;
`ifdef SB_COALESCE_EN
      merge = st_valid && n > 0 && q[n-1].addr[13:2] == st_addr[13:2] && !(mem_grant && n == 1);
`endif
      exp_ready = (n < DEPTH) || merge;
      exp_we    = (n > 0) && mem_grant;
      model_fwd(cov, fd);
      chk("st_ready",    32'(st_ready),    32'(exp_ready));
      chk("sb_count",    32'(sb_count),    32'(n));
      chk("sb_empty",    32'(sb_empty),    32'(n == 0));
      chk("mem_we",      32'(mem_we),      32'(exp_we));
      chk("mem_addr",    mem_addr,         n > 0 ? q[0].addr : 32'h0);
      chk("mem_wdata",   mem_wdata,        n > 0 ? q[0].data : 32'h0);
      chk("mem_byte_en", 32'(mem_byte_en), n > 0 ? 32'(q[0].be) : 32'h0);
      chk("ld_hit",      32'(ld_hit),      32'(ld_byte_en != 4'h0 && cov == ld_byte_en));
      chk("ld_conflict", 32'(ld_conflict), 32'(cov != 4'h0 && cov != ld_byte_en));
      chk("ld_data",     ld_data,          fd);
      @(posedge clk);
      if (!reset) begin
         q.delete();
      end else begin
         if (st_valid && exp_ready && merge) begin
            for (int b = 0; b < 4; b++) begin
               if (st_byte_en[b]) q[n-1].data[8*b +: 8] = st_data[8*b +: 8];
            end
            q[n-1].be = q[n-1].be | st_byte_en;
         end
         if (exp_we) begin
            drained.push_back(q[0].addr);
            void'(q.pop_front());
         end
         if (st_valid && exp_ready && !merge) begin
            q.push_back('{addr: st_addr, data: st_data, be: st_byte_en});
            accepted.push_back(st_addr);
         end
      end
      #1;
   endtask

   task automatic drain_all(input string tag);
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 4'h0);
      for (int k = 0; k < 4 * DEPTH && q.size() > 0; k++) tick();
      #1;
      chk(tag, 32'(sb_empty), 32'h1);
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      // Reset held with a store and a grant present: reset must win.
      drive(1'b1, 32'h40, 32'h12345678, 4'hF, 1'b1, 32'h40, 4'hF);
      #1;
      chk("rst_st_ready", 32'(st_ready), 32'h1);
      chk("rst_mem_we",   32'(mem_we),   32'h0);
      chk("rst_ld_data",  ld_data,       32'h0);
      tick();
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
      tick();

      // Single store then a full-word forwarding hit.
      drive(1'b1, 32'h100, 32'hCAFEBABE, 4'hF, 1'b0, 32'h0, 4'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h100, 4'hF);
      #1;
      chk("d037_count", 32'(sb_count), 32'h1);
      chk("d037_hit",   32'(ld_hit),   32'h1);
      chk("d037_data",  ld_data,       32'hCAFEBABE);
      tick();
      drain_all("d037_drained");

      // Fill to DEPTH, hold the next store, then one granted drain.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 1'b0, 32'h0, 4'h0);
         tick();
      end
      drive(1'b1, 32'h500, 32'h55, 4'hF, 1'b0, 32'h0, 4'h0);
      #1;
      chk("d038_full_ready", 32'(st_ready), 32'h0);
      tick();
      mem_grant = 1'b1;
      #1;
      chk("d038_we",          32'(mem_we),   32'h1);
      chk("d038_addr",        mem_addr,      32'h200);
      chk("d038_ready_same",  32'(st_ready), 32'h0);
      tick();
      mem_grant = 1'b0;
      #1;
      chk("d038_ready_next",  32'(st_ready), 32'h1);
      tick();
      drain_all("d038_drained");

      // Partial coverage stalls the load; after drain there is no match at all.
      drive(1'b1, 32'h104, 32'h99, 4'h1, 1'b0, 32'h0, 4'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h104, 4'hF);
      #1;
      chk("d039_conflict", 32'(ld_conflict), 32'h1);
      chk("d039_hit",      32'(ld_hit),      32'h0);
      tick();
      drain_all("d039_drained");
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h104, 4'hF);
      #1;
      chk("d039_conflict_after", 32'(ld_conflict), 32'h0);
      chk("d039_hit_after",      32'(ld_hit),      32'h0);
      tick();

      // Youngest entry wins per lane.
      drive(1'b1, 32'h0, 32'h1111, 4'h3, 1'b0, 32'h0, 4'h0);
      tick();
      drive(1'b1, 32'h0, 32'h22, 4'h1, 1'b0, 32'h0, 4'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h3);
      #1;
      chk("d040_data", ld_data, 32'h00001122);
`ifdef SB_COALESCE_EN
      chk("d040_count", 32'(sb_count), 32'h1);
`else
      chk("d040_count", 32'(sb_count), 32'h2);
`endif
      tick();
      drain_all("d040_drained");

      // Pending entries discarded by reset; nothing written afterwards.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(i * 4), 32'hD0 + 32'(i), 4'hF, 1'b0, 32'h0, 4'h0);
         tick();
      end
      reset = 1'b0;
      drive(1'b1, 32'h700, 32'h77, 4'hF, 1'b1, 32'h300, 4'hF);
      tick();
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300, 4'hF);
      #1;
      chk("d041_empty", 32'(sb_empty), 32'h1);
      chk("d041_count", 32'(sb_count), 32'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("d041_no_we", 32'(mem_we), 32'h0);
         tick();
      end

      // Pointer wrap: drain order must equal acceptance order.
      accepted.delete();
      drained.delete();
      for (int i = 0; i < 2 * DEPTH + 1; i++) begin
         drive(1'b1, 32'h1000 + 32'(i * 4), 32'hB0 + 32'(i), 4'hF, 1'b1, 32'h0, 4'h0);
         tick();
      end
      drain_all("d042_drained");
      chk("d042_n_drained", 32'(drained.size()), 32'(2 * DEPTH + 1));
      for (int i = 0; i < drained.size() && i < accepted.size(); i++) begin
         chk("d042_order", drained[i], accepted[i]);
      end

      // Random traffic over a small address window, aliases and low-bit noise included.
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 59) != 0);
         drive(1'($urandom_range(0, 1)),
               {17'h0, 1'($urandom_range(0, 1)), 10'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
               $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0),
               {17'h0, 1'($urandom_range(0, 1)), 10'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
               4'($urandom_range(0, 15)));
         tick();
      end
      reset = 1'b1;
      drain_all("rand_drained");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
